// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared MIPS pipeline control-bit indices and MEM-stage FSM codes.
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int MEM_BRANCH  = 2;
    localparam int MEM_READ    = 1;
    localparam int MEM_WRITE   = 0;

    typedef logic [1:0] memState_t;

    localparam memState_t IDLE  = 2'd0;
    localparam memState_t WAIT  = 2'd1;
    localparam memState_t ABORT = 2'd2;

    // Read and write both set is treated as a write, so only MemRead alone loads.
    function automatic logic isLoad(input logic [2:0] memCtl);
        return memCtl[MEM_READ] & ~memCtl[MEM_WRITE];
    endfunction

endpackage
`default_nettype wire

// File: rtl/memwb_reg.sv
`default_nettype none
// ============================================================================
// Module   : memwb_reg
// Purpose  : MEM/WB pipeline register; a bubble clears control, data holds.
// Revision : 1.0  initial release
// ============================================================================
module memwb_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bubble,
    input  logic              i_ldData,
    input  logic [1:0]        i_wb,
    input  logic [DATA_W-1:0] i_rdData,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [REG_W-1:0]  i_wrDst,
    output logic [1:0]        o_wb,
    output logic [DATA_W-1:0] o_rdData,
    output logic [DATA_W-1:0] o_alu,
    output logic [REG_W-1:0]  o_wrDst
);

    logic [1:0]        r_wb;
    logic [DATA_W-1:0] r_rdData;
    logic [DATA_W-1:0] r_alu;
    logic [REG_W-1:0]  r_wrDst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb     <= 2'b00;
            r_rdData <= '0;
            r_alu    <= '0;
            r_wrDst  <= '0;
        end else if (i_bubble) begin
            r_wb <= 2'b00;
        end else begin
            r_wb    <= i_wb;
            r_alu   <= i_alu;
            r_wrDst <= i_wrDst;
            if (i_ldData) begin
                r_rdData <= i_rdData;
            end
        end
    end

    assign o_wb     = r_wb;
    assign o_rdData = r_rdData;
    assign o_alu    = r_alu;
    assign o_wrDst  = r_wrDst;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MIPS MEM stage: branch resolve, variable-latency dmem handshake
//            with timeout abort, MEM/WB register. MEM_ALIGN_CHECK_EN adds
//            misaligned-access rejection and the align_err pulse.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        wb_in,
    input  logic [2:0]        mem_in,
    input  logic [DATA_W-1:0] br_dst,
    input  logic              z_flag,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rt_in,
    input  logic [REG_W-1:0]  wr_dst_in,
    output logic              pc_src,
    output logic [DATA_W-1:0] br_target,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              bus_err,
    output logic [1:0]        wb_out,
    output logic [DATA_W-1:0] rd_data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  wr_dst_out
`ifdef MEM_ALIGN_CHECK_EN
   ,output logic              align_err
`endif
);

    localparam logic [7:0] c_timeoutCnt = 8'(TIMEOUT);

    memState_t  r_state;
    memState_t  w_nextState;
    logic [7:0] r_waitCnt;
    logic [7:0] w_nextCnt;
    logic       r_busErr;
    logic       w_access;
    logic       w_misalign;
    logic       w_accessOk;
    logic       w_notAbort;
    logic       w_stall;
    logic       w_bubble;
    logic       w_ldData;

    assign w_access = mem_in[MEM_READ] | mem_in[MEM_WRITE];

`ifdef MEM_ALIGN_CHECK_EN
    logic r_alignErr;

    assign w_misalign = w_access & (alu_in[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alignErr <= 1'b0;
        end else begin
            r_alignErr <= w_misalign;
        end
    end

    assign align_err = r_alignErr;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accessOk = w_access & ~w_misalign;
    assign w_notAbort = (r_state != ABORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_waitCnt <= 8'd0;
            r_busErr  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextCnt;
            r_busErr  <= (w_nextState == ABORT);
        end
    end

    // Leaving WAIT when access drops covers an upstream that breaks the hold rule.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_waitCnt;
        case (r_state)
            IDLE: begin
                if (w_accessOk & ~dmem_ack) begin
                    w_nextState = WAIT;
                    w_nextCnt   = 8'd1;
                end
            end
            WAIT: begin
                if (~w_accessOk | dmem_ack) begin
                    w_nextState = IDLE;
                    w_nextCnt   = 8'd0;
                end else if (r_waitCnt == c_timeoutCnt) begin
                    w_nextState = ABORT;
                    w_nextCnt   = 8'd0;
                end else begin
                    w_nextCnt = r_waitCnt + 8'd1;
                end
            end
            ABORT: begin
                w_nextState = IDLE;
                w_nextCnt   = 8'd0;
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = 8'd0;
            end
        endcase
    end

    always_comb begin
        w_stall  = w_accessOk & ~dmem_ack & w_notAbort;
        w_bubble = w_stall | ~w_notAbort | w_misalign;
        w_ldData = w_accessOk & dmem_ack & w_notAbort & isLoad(mem_in);
    end

    assign pc_src     = mem_in[MEM_BRANCH] & z_flag;
    assign br_target  = br_dst;
    assign stall      = w_stall;
    assign dmem_req   = w_accessOk & w_notAbort;
    assign dmem_we    = mem_in[MEM_WRITE];
    assign dmem_addr  = alu_in;
    assign dmem_wdata = rt_in;
    assign bus_err    = r_busErr;

    memwb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_memwb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (w_bubble),
        .i_ldData (w_ldData),
        .i_wb     (wb_in),
        .i_rdData (dmem_rdata),
        .i_alu    (alu_in),
        .i_wrDst  (wr_dst_in),
        .o_wb     (wb_out),
        .o_rdData (rd_data_out),
        .o_alu    (alu_out),
        .o_wrDst  (wr_dst_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: vector table, handshake corner
//            sequences and randomized latency traffic against a latency model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    wb_in;
    logic [2:0]    mem_in;
    logic [DW-1:0] br_dst;
    logic          z_flag;
    logic [DW-1:0] alu_in;
    logic [DW-1:0] rt_in;
    logic [RW-1:0] wr_dst_in;
    logic          pc_src;
    logic [DW-1:0] br_target;
    logic          stall;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic          bus_err;
    logic [1:0]    wb_out;
    logic [DW-1:0] rd_data_out;
    logic [DW-1:0] alu_out;
    logic [RW-1:0] wr_dst_out;
`ifdef MEM_ALIGN_CHECK_EN
    logic          align_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_in       (wb_in),
        .mem_in      (mem_in),
        .br_dst      (br_dst),
        .z_flag      (z_flag),
        .alu_in      (alu_in),
        .rt_in       (rt_in),
        .wr_dst_in   (wr_dst_in),
        .pc_src      (pc_src),
        .br_target   (br_target),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .bus_err     (bus_err),
        .wb_out      (wb_out),
        .rd_data_out (rd_data_out),
        .alu_out     (alu_out),
        .wr_dst_out  (wr_dst_out)
`ifdef MEM_ALIGN_CHECK_EN
       ,.align_err   (align_err)
`endif
    );

    typedef struct {
        logic [2:0]  memIn;
        logic [1:0]  wbIn;
        logic        z;
        logic [31:0] brDst;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  dst;
        logic        ack;
        logic [31:0] rdata;
        logic        expPc;
        logic        expReq;
        logic        expWe;
        logic [1:0]  expWb;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] m, input logic [1:0] w, input logic z,
                         input logic [31:0] b, input logic [31:0] a, input logic [31:0] r,
                         input logic [4:0] d, input logic k, input logic [31:0] rd);
        mem_in     = m;
        wb_in      = w;
        z_flag     = z;
        br_dst     = b;
        alu_in     = a;
        rt_in      = r;
        wr_dst_in  = d;
        dmem_ack   = k;
        dmem_rdata = rd;
    endtask

    // Random-phase state, reference MEM/WB contents
    logic [2:0]  rm;
    logic [1:0]  rw;
    logic        rz;
    logic [31:0] rb, ra, rr;
    logic [4:0]  rd5;
    logic        acc, waiting, abortCyc;
    int          lat, ncyc;
    logic [1:0]  expWb;
    logic [31:0] expRd, expAlu;
    logic [4:0]  expDst;

    initial begin
        vecs[0] = '{3'b010, 2'b11, 1'b0, 32'h0,  32'h100, 32'h5,    5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 2'b11, 32'hDEADBEEF};
        vecs[1] = '{3'b001, 2'b00, 1'b0, 32'h0,  32'h104, 32'hCAFE, 5'd4, 1'b1, 32'h1111,     1'b0, 1'b1, 1'b1, 2'b00, 32'hDEADBEEF};
        vecs[2] = '{3'b100, 2'b00, 1'b1, 32'h40, 32'h0,   32'h0,    5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF};
        vecs[3] = '{3'b100, 2'b00, 1'b0, 32'h40, 32'h0,   32'h0,    5'd0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF};
        vecs[4] = '{3'b000, 2'b10, 1'b0, 32'h0,  32'h20,  32'h0,    5'd7, 1'b1, 32'h2222,     1'b0, 1'b0, 1'b0, 2'b10, 32'hDEADBEEF};
        vecs[5] = '{3'b011, 2'b10, 1'b0, 32'h0,  32'h108, 32'h9,    5'd8, 1'b1, 32'h3333,     1'b0, 1'b1, 1'b1, 2'b10, 32'hDEADBEEF};
        vecs[6] = '{3'b010, 2'b11, 1'b0, 32'h0,  32'h10C, 32'h0,    5'd9, 1'b1, 32'h12345678, 1'b0, 1'b1, 1'b0, 2'b11, 32'h12345678};

        rst_n = 1'b0;
        drive(3'b000, 2'b00, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_out", wb_out, 2'b00);
        chk("reset_rd_data", rd_data_out, 0);
        chk("reset_alu_out", alu_out, 0);
        chk("reset_wr_dst", wr_dst_out, 0);
        chk("reset_bus_err", bus_err, 0);
        chk("reset_req", dmem_req, 0);
        rst_n = 1'b1;

        // Single-cycle vectors: zero-wait accesses, branches, bubbles
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].memIn, vecs[i].wbIn, vecs[i].z, vecs[i].brDst, vecs[i].alu,
                  vecs[i].rt, vecs[i].dst, vecs[i].ack, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("vec%0d_pc_src", i), pc_src, vecs[i].expPc);
            chk($sformatf("vec%0d_br_target", i), br_target, vecs[i].brDst);
            chk($sformatf("vec%0d_stall", i), stall, 0);
            chk($sformatf("vec%0d_req", i), dmem_req, vecs[i].expReq);
            chk($sformatf("vec%0d_we", i), dmem_we, vecs[i].expWe);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wb_out", i), wb_out, vecs[i].expWb);
            chk($sformatf("vec%0d_rd_data", i), rd_data_out, vecs[i].expRd);
            chk($sformatf("vec%0d_wr_dst", i), wr_dst_out, vecs[i].dst);
            chk($sformatf("vec%0d_alu_out", i), alu_out, vecs[i].alu);
        end

        // Store acknowledged on its third cycle
        drive(3'b001, 2'b10, 1'b0, '0, 32'h200, 32'hA5A5, 5'd5, 1'b0, '0);
        @(negedge clk);
        chk("st_stall1", stall, 1);
        chk("st_we", dmem_we, 1);
        chk("st_wdata1", dmem_wdata, 32'hA5A5);
        chk("st_req", dmem_req, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("st_stall2", stall, 1);
        chk("st_wb_bubble1", wb_out, 2'b00);
        chk("st_wdata2", dmem_wdata, 32'hA5A5);
        @(posedge clk);
        #1;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("st_stall3", stall, 0);
        chk("st_wb_bubble2", wb_out, 2'b00);
        @(posedge clk);
        #1;
        chk("st_wb_done", wb_out, 2'b10);
        chk("st_wr_dst", wr_dst_out, 5'd5);
        chk("st_alu_out", alu_out, 32'h200);
        chk("st_rd_hold", rd_data_out, 32'h12345678);

        // Read that never gets an ack: T+1 stall cycles then one abort cycle
        drive(3'b010, 2'b11, 1'b0, '0, 32'h300, '0, 5'd6, 1'b0, 32'h77);
        for (int c = 0; c <= T; c++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", c), stall, 1);
            chk($sformatf("to_buserr_low%0d", c), bus_err, 0);
            if (c > 0) chk($sformatf("to_wb_bubble%0d", c), wb_out, 2'b00);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("to_abort_stall", stall, 0);
        chk("to_abort_req", dmem_req, 0);
        chk("to_abort_buserr", bus_err, 1);
        chk("to_abort_wb", wb_out, 2'b00);
        @(posedge clk);
        #1;
        drive(3'b000, 2'b00, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        @(negedge clk);
        chk("to_buserr_pulse_end", bus_err, 0);
        chk("to_wb_after", wb_out, 2'b00);
        chk("to_rd_hold", rd_data_out, 32'h12345678);
        chk("to_idle_req", dmem_req, 0);
        @(posedge clk);
        #1;

        // Reset asserted while waiting with wait_cnt==2
        drive(3'b000, 2'b10, 1'b0, '0, 32'h55, '0, 5'd9, 1'b0, '0);
        @(posedge clk);
        #1;
        drive(3'b001, 2'b11, 1'b0, '0, 32'h400, 32'h9, 5'd7, 1'b0, '0);
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("rst_pre_alu", alu_out, 32'h55);
        rst_n = 1'b0;
        #1;
        chk("rst_async_wb", wb_out, 2'b00);
        chk("rst_async_rd", rd_data_out, 0);
        chk("rst_async_alu", alu_out, 0);
        chk("rst_async_dst", wr_dst_out, 0);
        chk("rst_async_buserr", bus_err, 0);
        drive(3'b000, 2'b00, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        #1;
        chk("rst_req_drop", dmem_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_after_req", dmem_req, 0);
        chk("rst_after_stall", stall, 0);
        chk("rst_after_wb", wb_out, 2'b00);
        @(posedge clk);
        #1;

`ifdef MEM_ALIGN_CHECK_EN
        drive(3'b010, 2'b11, 1'b0, '0, 32'h102, '0, 5'd2, 1'b0, 32'hBAD);
        @(negedge clk);
        chk("al_req", dmem_req, 0);
        chk("al_stall", stall, 0);
        chk("al_err_pre", align_err, 0);
        @(posedge clk);
        #1;
        drive(3'b000, 2'b00, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        chk("al_err_pulse", align_err, 1);
        chk("al_wb", wb_out, 2'b00);
        @(posedge clk);
        #1;
        chk("al_err_end", align_err, 0);
`endif

        // Randomized traffic; model counts stall cycles from the chosen ack latency
        expWb  = 2'b00;
        expRd  = '0;
        expAlu = '0;
        expDst = '0;
        for (int n = 0; n < 150; n++) begin
            rm  = 3'($urandom_range(0, 7));
            rw  = 2'($urandom_range(0, 3));
            rz  = 1'($urandom_range(0, 1));
            rb  = $urandom;
            ra  = $urandom;
            rr  = $urandom;
            rd5 = 5'($urandom_range(0, 31));
`ifdef MEM_ALIGN_CHECK_EN
            ra  = ra & ~32'h3;
`endif
            acc  = rm[1] | rm[0];
            lat  = acc ? $urandom_range(0, T + 2) : 0;
            ncyc = !acc ? 1 : (lat <= T ? lat + 1 : T + 2);
            for (int k = 0; k < ncyc; k++) begin
                abortCyc = acc && (lat > T) && (k == T + 1);
                waiting  = acc && !abortCyc && (k < lat);
                drive(rm, rw, rz, rb, ra, rr, rd5,
                      (acc && !abortCyc) ? (k == lat) : 1'($urandom_range(0, 1)),
                      $urandom);
                @(negedge clk);
                chk("rnd_stall", stall, waiting);
                chk("rnd_req", dmem_req, acc && !abortCyc);
                chk("rnd_we", dmem_we, rm[0]);
                chk("rnd_addr", dmem_addr, ra);
                chk("rnd_wdata", dmem_wdata, rr);
                chk("rnd_pc_src", pc_src, rm[2] & rz);
                chk("rnd_br_target", br_target, rb);
                chk("rnd_bus_err", bus_err, abortCyc);
                chk("rnd_wb_out", wb_out, expWb);
                chk("rnd_rd_data", rd_data_out, expRd);
                chk("rnd_alu_out", alu_out, expAlu);
                chk("rnd_wr_dst", wr_dst_out, expDst);
                if (waiting || abortCyc) begin
                    expWb = 2'b00;
                end else begin
                    expWb  = rw;
                    expAlu = ra;
                    expDst = rd5;
                    if (rm == 3'b010 || rm == 3'b110) expRd = dmem_rdata;
                end
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
